// File: rtl/cp0_except_unit_pkg.sv
// cp0_except_unit_pkg: CP0 register addresses, exception codes and the default exception vector
package cp0_except_unit_pkg;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exc_code_e;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with half-rate tick and timer-interrupt flag TI
// ports: clk, rst (async, active-high); count_we/compare_we + wdata write the registers;
//        count, compare, ti are the current register contents
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    logic tick;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick    <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            tick    <= count_we ? 1'b0 : ~tick;
            count   <= count_we ? wdata : count + {31'b0, tick};
            compare <= compare_we ? wdata : compare;
            ti      <= compare_we ? 1'b0 : (ti | (count == compare));
        end
    end
endmodule

// File: rtl/cp0_except_unit.sv
// cp0_except_unit: MEM-stage exception arbitration and CP0 register file
// ports: clk, rst (async, active-high); inst_valid + exception flags, pc, bad_addr, in_delayslot
//        from MEM; hw_int interrupt lines; cp0_we/waddr/wdata (MTC0); cp0_raddr/rdata (MFC0);
//        flush/exc_pc redirect the pipeline; status/cause/epc expose the live registers
module cp0_except_unit
    import cp0_except_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic        eret_flag,
    input  logic        syscall_flag,
    input  logic        break_flag,
    input  logic        overflow_flag,
    input  logic        invalid_inst_flag,
    input  logic        adel_flag,
    input  logic        ades_flag,
    input  logic [31:0] pc,
    input  logic [31:0] bad_addr,
    input  logic        in_delayslot,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] exc_pc,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc
);
    logic [31:0] badvaddr, count, compare;
    logic [7:0]  im, ip;
    logic        exl, ie, bd, ti;
    exc_code_e   exc_code, code;
    logic        v, int_req, exc, eret_take, we;

    assign status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause  = {bd, ti, 14'b0, ip, 1'b0, exc_code, 2'b0};

    // reset also silences the redirect so flush stays low while rst is held
    always_comb begin
        v         = inst_valid & ~rst;
        int_req   = v & ie & ~exl & |(ip & im);
        exc       = int_req | (v & (adel_flag | invalid_inst_flag | overflow_flag |
                                    syscall_flag | break_flag | ades_flag));
        code      = int_req           ? EXC_INT  :
                    adel_flag         ? EXC_ADEL :
                    invalid_inst_flag ? EXC_RI   :
                    overflow_flag     ? EXC_OV   :
                    syscall_flag      ? EXC_SYS  :
                    break_flag        ? EXC_BP   : EXC_ADES;
        eret_take = v & eret_flag & ~exc;
        flush     = exc | eret_take;
        exc_pc    = exc ? EXC_VECTOR : eret_take ? epc : 32'h0;
        we        = cp0_we & ~flush;
        cp0_rdata = cp0_raddr == REG_BADVADDR ? badvaddr :
                    cp0_raddr == REG_COUNT    ? count    :
                    cp0_raddr == REG_COMPARE  ? compare  :
                    cp0_raddr == REG_STATUS   ? status   :
                    cp0_raddr == REG_CAUSE    ? cause    :
                    cp0_raddr == REG_EPC      ? epc      : 32'h0;
    end

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we && cp0_waddr == REG_COUNT),
        .compare_we (we && cp0_waddr == REG_COMPARE),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr <= '0;
            epc      <= '0;
            im       <= '0;
            ip       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= EXC_INT;
        end else begin
            ip[7:2] <= {hw_int[5] | ti, hw_int[4:0]};
            if (exc) begin
                exl      <= 1'b1;
                exc_code <= code;
                // a nested exception keeps the original return point
                if (!exl) begin
                    epc <= in_delayslot ? pc - 32'd4 : pc;
                    bd  <= in_delayslot;
                end
                if (code == EXC_ADEL || code == EXC_ADES)
                    badvaddr <= bad_addr;
            end else if (eret_take) begin
                exl <= 1'b0;
            end else if (we) begin
                if (cp0_waddr == REG_STATUS) begin
                    im  <= cp0_wdata[15:8];
                    exl <= cp0_wdata[1];
                    ie  <= cp0_wdata[0];
                end
                if (cp0_waddr == REG_CAUSE)
                    ip[1:0] <= cp0_wdata[9:8];
                if (cp0_waddr == REG_EPC)
                    epc <= cp0_wdata;
            end
        end
    end
endmodule
